rip_ma_writeback: RTL and testbench

- Memory-access/writeback stage of the rip pipeline. Owns the producer side of the register-file write port: ma_rd_num, wen, wdata.
- Takes EX results and data-memory load responses, then aligns and sign/zero-extends load data.
- Stalls upstream while a load is outstanding, and flags illegal or misaligned loads and load timeouts.

---
 rtl/rip_ma_writeback.sv | 179 +++++++++++++++++
 tb/tb_rip_ma_writeback.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rip_ma_writeback.sv
// Memory-access / writeback stage of the rip pipeline: drives the regfile write port and aligns and extends load data.
// Optional performance counters are compiled in when RIP_WB_PERF_EN is defined.
module rip_ma_writeback #(
    parameter int unsigned LOAD_TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ex_valid,
    input  logic        ex_reg_wen,
    input  logic [4:0]  ex_rd_num,
    input  logic        ex_is_load,
    input  logic [2:0]  ex_funct3,
    input  logic [31:0] ex_alu_result,
    input  logic        dmem_rvalid,
    input  logic [31:0] dmem_rdata,
    output logic [4:0]  ma_rd_num,
    output logic        wen,
    output logic [31:0] wdata,
    output logic        ma_stall,
    output logic        ma_load_err
`ifdef RIP_WB_PERF_EN
    ,
    output logic [31:0] perf_load_stall_cycles,
    output logic [31:0] perf_writes
`endif
);

    typedef enum logic {
        IDLE,
        WAIT_LOAD
    } state_t;

    localparam int unsigned CW = (LOAD_TIMEOUT < 2) ? 1 : $clog2(LOAD_TIMEOUT + 1);
    localparam logic [CW-1:0] TO_LIMIT = CW'(LOAD_TIMEOUT);

    state_t          r_state;
    logic [CW-1:0]   r_cnt;
    logic [4:0]      r_ld_rd;
    logic            r_ld_wen;
    logic [2:0]      r_ld_f3;
    logic [1:0]      r_ld_off;
    logic [4:0]      r_rd_num;
    logic            r_wen;
    logic [31:0]     r_wdata;
    logic            r_err;

    state_t          w_state_nxt;
    logic [CW-1:0]   w_cnt_nxt;
    logic [CW-1:0]   w_cnt_inc;
    logic            w_capture;
    logic            w_load_ok;
    logic [4:0]      w_rd_nxt;
    logic            w_wen_nxt;
    logic [31:0]     w_wdata_nxt;
    logic            w_err_nxt;

    function automatic logic [31:0] extract(input logic [2:0] f3, input logic [1:0] off,
                                            input logic [31:0] word);
        logic [31:0] s;
        s = word >> {off, 3'b000};
        case (f3)
            3'b000:  return {{24{s[7]}}, s[7:0]};
            3'b001:  return {{16{s[15]}}, s[15:0]};
            3'b100:  return {24'd0, s[7:0]};
            3'b101:  return {16'd0, s[15:0]};
            default: return word;
        endcase
    endfunction

    always_comb begin
        case (ex_funct3)
            3'b000, 3'b100: w_load_ok = 1'b1;
            3'b001, 3'b101: w_load_ok = ~ex_alu_result[0];
            3'b010:         w_load_ok = (ex_alu_result[1:0] == 2'b00);
            default:        w_load_ok = 1'b0;
        endcase
    end

    assign w_cnt_inc = r_cnt + 1'b1;

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_capture   = 1'b0;
        w_rd_nxt    = r_rd_num;
        w_wen_nxt   = 1'b0;
        w_wdata_nxt = r_wdata;
        w_err_nxt   = 1'b0;
        case (r_state)
            IDLE: begin
                if (ex_valid) begin
                    if (!ex_is_load) begin
                        w_wen_nxt   = ex_reg_wen && (ex_rd_num != 5'd0);
                        w_rd_nxt    = ex_rd_num;
                        w_wdata_nxt = ex_alu_result;
                    end else if (w_load_ok) begin
                        w_capture   = 1'b1;
                        w_state_nxt = WAIT_LOAD;
                        w_cnt_nxt   = '0;
                    end else begin
                        w_err_nxt = 1'b1;
                    end
                end
            end
            WAIT_LOAD: begin
                // Data arriving on the limit cycle takes priority over the abort.
                if (dmem_rvalid) begin
                    w_wen_nxt   = r_ld_wen && (r_ld_rd != 5'd0);
                    w_rd_nxt    = r_ld_rd;
                    w_wdata_nxt = extract(r_ld_f3, r_ld_off, dmem_rdata);
                    w_state_nxt = IDLE;
                    w_cnt_nxt   = '0;
                end else if ((LOAD_TIMEOUT != 0) && (w_cnt_inc == TO_LIMIT)) begin
                    w_err_nxt   = 1'b1;
                    w_state_nxt = IDLE;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt = w_cnt_inc;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state  <= IDLE;
            r_cnt    <= '0;
            r_ld_rd  <= 5'd0;
            r_ld_wen <= 1'b0;
            r_ld_f3  <= 3'd0;
            r_ld_off <= 2'd0;
            r_rd_num <= 5'd0;
            r_wen    <= 1'b0;
            r_wdata  <= 32'd0;
            r_err    <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_cnt    <= w_cnt_nxt;
            r_rd_num <= w_rd_nxt;
            r_wen    <= w_wen_nxt;
            r_wdata  <= w_wdata_nxt;
            r_err    <= w_err_nxt;
            if (w_capture) begin
                r_ld_rd  <= ex_rd_num;
                r_ld_wen <= ex_reg_wen;
                r_ld_f3  <= ex_funct3;
                r_ld_off <= ex_alu_result[1:0];
            end
        end
    end

    assign ma_rd_num   = r_rd_num;
    assign wen         = r_wen;
    assign wdata       = r_wdata;
    assign ma_load_err = r_err;
    assign ma_stall    = (r_state == WAIT_LOAD);

`ifdef RIP_WB_PERF_EN
    logic [31:0] r_perf_stall;
    logic [31:0] r_perf_writes;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_perf_stall  <= 32'd0;
            r_perf_writes <= 32'd0;
        end else begin
            if (ma_stall) r_perf_stall <= r_perf_stall + 32'd1;
            if (r_wen)    r_perf_writes <= r_perf_writes + 32'd1;
        end
    end

    assign perf_load_stall_cycles = r_perf_stall;
    assign perf_writes            = r_perf_writes;
`endif

endmodule

// File: tb/tb_rip_ma_writeback.sv
// Self-checking bench for rip_ma_writeback: vector table, hand-written load/timeout/reset sequences,
// and a randomized run against a transaction-level reference model.
module tb_rip_ma_writeback;

    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ex_valid, ex_reg_wen, ex_is_load, dmem_rvalid;
    logic [4:0]  ex_rd_num;
    logic [2:0]  ex_funct3;
    logic [31:0] ex_alu_result, dmem_rdata;
    logic [4:0]  ma_rd_num;
    logic        wen, ma_stall, ma_load_err;
    logic [31:0] wdata;
`ifdef RIP_WB_PERF_EN
    logic [31:0] perf_load_stall_cycles, perf_writes;
`endif

    rip_ma_writeback #(.LOAD_TIMEOUT(TO)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .ex_valid      (ex_valid),
        .ex_reg_wen    (ex_reg_wen),
        .ex_rd_num     (ex_rd_num),
        .ex_is_load    (ex_is_load),
        .ex_funct3     (ex_funct3),
        .ex_alu_result (ex_alu_result),
        .dmem_rvalid   (dmem_rvalid),
        .dmem_rdata    (dmem_rdata),
        .ma_rd_num     (ma_rd_num),
        .wen           (wen),
        .wdata         (wdata),
        .ma_stall      (ma_stall),
        .ma_load_err   (ma_load_err)
`ifdef RIP_WB_PERF_EN
        ,
        .perf_load_stall_cycles (perf_load_stall_cycles),
        .perf_writes            (perf_writes)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    typedef struct {
        logic        ld;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] rdata;
        logic [4:0]  rd;
        logic        rw;
        logic        e_err;
        logic        e_wen;
        logic [31:0] e_wdata;
    } vec_t;

    vec_t vecs[14];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic drive(input logic v, input logic ld, input logic [2:0] f3, input logic [31:0] alu,
                         input logic [4:0] rd, input logic rw, input logic rv, input logic [31:0] rdata);
        ex_valid      = v;
        ex_is_load    = ld;
        ex_funct3     = f3;
        ex_alu_result = alu;
        ex_rd_num     = rd;
        ex_reg_wen    = rw;
        dmem_rvalid   = rv;
        dmem_rdata    = rdata;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(0, 0, 3'd0, 32'd0, 5'd0, 0, 0, 32'd0);
    endtask

    function automatic logic [31:0] m_extract(input logic [2:0] f3, input logic [1:0] off,
                                              input logic [31:0] w);
        longint unsigned nb, full, v;
        nb = 64'd1 << f3[1:0];
        if (nb == 4) return w;
        full = 64'd1 << (8 * nb);
        v = ({32'd0, w} >> (8 * off)) % full;
        if (!f3[2] && v >= full / 2) v = v + ((64'd1 << 32) - full);
        return v[31:0];
    endfunction

    function automatic bit m_legal(input logic [2:0] f3, input logic [31:0] addr);
        int nb;
        if (!(f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5})) return 1'b0;
        nb = 1 << f3[1:0];
        return (addr % nb) == 0;
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        bit              pend, p_wen, e_wen, e_err;
        logic [4:0]      p_rd, e_rd;
        logic [2:0]      p_f3;
        logic [1:0]      p_off;
        logic [31:0]     e_wdata;
        int              waited;
        bit              wen_vis;
        int unsigned     m_perf_stall, m_perf_wr;
        logic            v, ld, rw, rv;
        logic [2:0]      f3;
        logic [31:0]     addr, rdata;
        logic [4:0]      rd;

        vecs[0]  = '{0, 3'b000, 32'h1234_5678, 32'h0,          5'd5,  1, 0, 1, 32'h1234_5678};
        vecs[1]  = '{0, 3'b000, 32'h1234_5678, 32'h0,          5'd0,  1, 0, 0, 32'h0};
        vecs[2]  = '{0, 3'b000, 32'h0000_00A5, 32'h0,          5'd7,  0, 0, 0, 32'h0};
        vecs[3]  = '{1, 3'b010, 32'h0000_0100, 32'hDEAD_BEEF,  5'd10, 1, 0, 1, 32'hDEAD_BEEF};
        vecs[4]  = '{1, 3'b001, 32'h0000_0202, 32'h7FFF_0000,  5'd11, 1, 0, 1, 32'h0000_7FFF};
        vecs[5]  = '{1, 3'b101, 32'h0000_0300, 32'h1234_8001,  5'd12, 1, 0, 1, 32'h0000_8001};
        vecs[6]  = '{1, 3'b001, 32'h0000_0300, 32'h1234_8001,  5'd13, 1, 0, 1, 32'hFFFF_8001};
        vecs[7]  = '{1, 3'b000, 32'h0000_0401, 32'h0000_8000,  5'd14, 1, 0, 1, 32'hFFFF_FF80};
        vecs[8]  = '{1, 3'b100, 32'h0000_0402, 32'h00AB_0000,  5'd15, 1, 0, 1, 32'h0000_00AB};
        vecs[9]  = '{1, 3'b001, 32'h0000_0201, 32'h7FFF_0000,  5'd16, 1, 1, 0, 32'h0};
        vecs[10] = '{1, 3'b010, 32'h0000_0102, 32'h1111_1111,  5'd17, 1, 1, 0, 32'h0};
        vecs[11] = '{1, 3'b011, 32'h0000_0100, 32'h1111_1111,  5'd18, 1, 1, 0, 32'h0};
        vecs[12] = '{1, 3'b110, 32'h0000_0100, 32'h1111_1111,  5'd19, 1, 1, 0, 32'h0};
        vecs[13] = '{1, 3'b000, 32'h0000_0100, 32'h0000_00FF,  5'd0,  1, 0, 0, 32'h0};

        rst_n = 1'b0;
        idle(3);
        check("reset wen", 32'(wen), 32'd0);
        check("reset rd", 32'(ma_rd_num), 32'd0);
        check("reset wdata", wdata, 32'd0);
        check("reset err", 32'(ma_load_err), 32'd0);
        check("reset stall", 32'(ma_stall), 32'd0);
        rst_n = 1'b1;
        idle(1);

        for (int i = 0; i < 14; i++) begin
            drive(1, vecs[i].ld, vecs[i].f3, vecs[i].addr, vecs[i].rd, vecs[i].rw, 0, 32'd0);
            if (!vecs[i].ld) begin
                check($sformatf("vec%0d wen", i), 32'(wen), 32'(vecs[i].e_wen));
                if (vecs[i].e_wen) begin
                    check($sformatf("vec%0d rd", i), 32'(ma_rd_num), 32'(vecs[i].rd));
                    check($sformatf("vec%0d wdata", i), wdata, vecs[i].e_wdata);
                end
                check($sformatf("vec%0d err", i), 32'(ma_load_err), 32'd0);
                check($sformatf("vec%0d stall", i), 32'(ma_stall), 32'd0);
            end else if (vecs[i].e_err) begin
                check($sformatf("vec%0d err", i), 32'(ma_load_err), 32'd1);
                check($sformatf("vec%0d wen", i), 32'(wen), 32'd0);
                check($sformatf("vec%0d stall", i), 32'(ma_stall), 32'd0);
                idle(1);
                check($sformatf("vec%0d err pulse", i), 32'(ma_load_err), 32'd0);
            end else begin
                check($sformatf("vec%0d stall", i), 32'(ma_stall), 32'd1);
                check($sformatf("vec%0d wait wen", i), 32'(wen), 32'd0);
                drive(0, 0, 3'd0, 32'd0, 5'd0, 0, 1, vecs[i].rdata);
                check($sformatf("vec%0d stall done", i), 32'(ma_stall), 32'd0);
                check($sformatf("vec%0d wen", i), 32'(wen), 32'(vecs[i].e_wen));
                if (vecs[i].e_wen) begin
                    check($sformatf("vec%0d rd", i), 32'(ma_rd_num), 32'(vecs[i].rd));
                    check($sformatf("vec%0d wdata", i), wdata, vecs[i].e_wdata);
                end
                check($sformatf("vec%0d err", i), 32'(ma_load_err), 32'd0);
            end
            idle(1);
        end

        // LB at offset 3 with data three cycles later; EX traffic during the wait must be ignored.
        drive(1, 1, 3'b000, 32'h0000_1003, 5'd3, 1, 0, 32'd0);
        check("lb stall1", 32'(ma_stall), 32'd1);
        drive(1, 0, 3'd0, 32'h99, 5'd9, 1, 0, 32'd0);
        check("lb stall2", 32'(ma_stall), 32'd1);
        check("lb ignore ex", 32'(wen), 32'd0);
        drive(1, 0, 3'd0, 32'h99, 5'd9, 1, 0, 32'd0);
        check("lb stall3", 32'(ma_stall), 32'd1);
        check("lb ignore ex2", 32'(wen), 32'd0);
        drive(1, 0, 3'd0, 32'h99, 5'd9, 1, 1, 32'h80AA_BBCC);
        check("lb stall end", 32'(ma_stall), 32'd0);
        check("lb wen", 32'(wen), 32'd1);
        check("lb rd", 32'(ma_rd_num), 32'd3);
        check("lb wdata", wdata, 32'hFFFF_FF80);
        drive(1, 0, 3'd0, 32'h99, 5'd9, 1, 0, 32'd0);
        check("held alu wen", 32'(wen), 32'd1);
        check("held alu rd", 32'(ma_rd_num), 32'd9);
        check("held alu wdata", wdata, 32'h99);
        drive(1, 1, 3'b100, 32'h0000_1003, 5'd4, 1, 0, 32'd0);
        idle(2);
        drive(0, 0, 3'd0, 32'd0, 5'd0, 0, 1, 32'h80AA_BBCC);
        check("lbu wen", 32'(wen), 32'd1);
        check("lbu wdata", wdata, 32'h0000_0080);

        // Illegal funct3 pulses once, then the following ALU op writes.
        drive(1, 1, 3'b011, 32'h0, 5'd6, 1, 0, 32'd0);
        check("f3 011 err", 32'(ma_load_err), 32'd1);
        drive(1, 0, 3'd0, 32'h0000_0777, 5'd6, 1, 0, 32'd0);
        check("f3 011 err clear", 32'(ma_load_err), 32'd0);
        check("after err wen", 32'(wen), 32'd1);
        check("after err wdata", wdata, 32'h0000_0777);

        // Timeout with no data.
        drive(1, 1, 3'b010, 32'h0, 5'd4, 1, 0, 32'd0);
        for (int i = 0; i < TO; i++) begin
            check($sformatf("to stall%0d", i), 32'(ma_stall), 32'd1);
            check($sformatf("to err early%0d", i), 32'(ma_load_err), 32'd0);
            idle(1);
        end
        check("to err", 32'(ma_load_err), 32'd1);
        check("to wen", 32'(wen), 32'd0);
        check("to idle", 32'(ma_stall), 32'd0);
        idle(1);
        check("to err pulse", 32'(ma_load_err), 32'd0);

        // Data on the limit cycle wins over the abort.
        drive(1, 1, 3'b010, 32'h0, 5'd4, 1, 0, 32'd0);
        idle(TO - 1);
        drive(0, 0, 3'd0, 32'd0, 5'd0, 0, 1, 32'hCAFE_F00D);
        check("limit rvalid wen", 32'(wen), 32'd1);
        check("limit rvalid wdata", wdata, 32'hCAFE_F00D);
        check("limit rvalid err", 32'(ma_load_err), 32'd0);
        idle(1);

        // Reset during WAIT_LOAD with data arriving while reset is held.
        drive(1, 1, 3'b010, 32'h0, 5'd8, 1, 0, 32'd0);
        idle(1);
        rst_n = 1'b0;
        drive(0, 0, 3'd0, 32'd0, 5'd0, 0, 1, 32'h5555_AAAA);
        check("rst load wen", 32'(wen), 32'd0);
        check("rst load stall", 32'(ma_stall), 32'd0);
        drive(0, 0, 3'd0, 32'd0, 5'd0, 0, 1, 32'h5555_AAAA);
`ifdef RIP_WB_PERF_EN
        check("rst perf stall", perf_load_stall_cycles, 32'd0);
        check("rst perf writes", perf_writes, 32'd0);
`endif
        rst_n = 1'b1;
        drive(0, 0, 3'd0, 32'd0, 5'd0, 0, 1, 32'h5555_AAAA);
        check("post rst wen", 32'(wen), 32'd0);
        check("post rst stall", 32'(ma_stall), 32'd0);
        check("post rst err", 32'(ma_load_err), 32'd0);

        // Randomized run against the transaction-level model.
        rst_n = 1'b0;
        idle(2);
        rst_n = 1'b1;
        pend = 0; p_wen = 0; p_rd = '0; p_f3 = '0; p_off = '0; waited = 0;
        wen_vis = 0; m_perf_stall = 0; m_perf_wr = 0;
        for (int c = 0; c < 2000; c++) begin
            v     = ($urandom_range(0, 9) < 7);
            ld    = $urandom_range(0, 1);
            f3    = 3'($urandom);
            addr  = $urandom;
            rd    = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom);
            rw    = ($urandom_range(0, 7) != 0);
            rv    = ($urandom_range(0, 3) == 0);
            rdata = $urandom;

            check("rnd stall", 32'(ma_stall), 32'(pend));
            if (pend) m_perf_stall++;
            if (wen_vis) m_perf_wr++;

            e_wen = 0; e_err = 0; e_rd = '0; e_wdata = '0;
            if (pend) begin
                if (rv) begin
                    e_wen   = p_wen && (p_rd != 0);
                    e_rd    = p_rd;
                    e_wdata = m_extract(p_f3, p_off, rdata);
                    pend    = 0;
                end else begin
                    waited++;
                    if (waited == TO) begin
                        e_err = 1;
                        pend  = 0;
                    end
                end
            end else if (v) begin
                if (!ld) begin
                    e_wen   = rw && (rd != 0);
                    e_rd    = rd;
                    e_wdata = addr;
                end else if (m_legal(f3, addr)) begin
                    pend = 1; p_wen = rw; p_rd = rd; p_f3 = f3; p_off = addr[1:0]; waited = 0;
                end else begin
                    e_err = 1;
                end
            end

            drive(v, ld, f3, addr, rd, rw, rv, rdata);
            check("rnd wen", 32'(wen), 32'(e_wen));
            check("rnd err", 32'(ma_load_err), 32'(e_err));
            if (e_wen) begin
                check("rnd rd", 32'(ma_rd_num), 32'(e_rd));
                check("rnd wdata", wdata, e_wdata);
            end
            wen_vis = e_wen;
        end
`ifdef RIP_WB_PERF_EN
        check("perf stall", perf_load_stall_cycles, m_perf_stall);
        check("perf writes", perf_writes, m_perf_wr);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
